pri_enc_seq: RTL and testbench
==============================

Name: pri_enc_seq

Overview:
Parametrised, registered N-input priority encoder/arbiter. It supports two modes: fixed priority, where the highest index wins, and round-robin, with a rotating base pointer. The winner is presented as a binary code plus a one-hot grant, and is held under a valid/ack handshake. It sits between multiple requesters and a shared resource, and replaces fixed 4-to-2 combinational encoding where fairness and a stable, held output are needed.

Parameters:
N, 8, number of request lines (N >= 2).
W, $clog2(N), code width. This is a derived localparam and is not overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i = requester i.
en  input  1  arbitration enable.
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
ack  input  1  consumer accepts the current grant.
valid  output  1  code/grant hold a live winner.
code  output  W  binary index of the winner.
grant  output  N  one-hot of the winner.
multi  output  1  more than one req bit was set at the grant's arbitration.

Behaviour:
- Single clock; reset is synchronous and active-high. Only clk and rst are used.
- Reset values: valid=0, code=0, grant=0, multi=0, rr pointer ptr=0, state=IDLE. Reset wins over every other input, including mid-HOLD: valid=0 after the edge regardless of ack.
- States:
  - IDLE: no live grant.
  - HOLD: valid=1, and outputs are frozen.
- Arbitration cycle: a cycle where (state==IDLE or (state==HOLD and ack)) and en=1 and |req.
  - At the edge that ends this cycle: code, grant and multi are loaded; valid=1; state=HOLD.
  - Latency is one cycle from a sampled req to valid.
- Fixed mode: the winner is the highest set index.
- Round-robin mode: search indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1, and the first set bit wins.
  - Only in RR mode, on each grant: ptr <= (winner+1) mod N. This wraps at N-1 to 0.
  - In fixed mode ptr is unchanged.
- HOLD with ack=1 but no new arbitration (en=0 or req=0): valid=0, grant=0, state=IDLE next edge. code keeps its last value.
- HOLD with ack=0: all outputs are stable, and req/en/mode changes are ignored. A grant is sticky even if its request withdraws.
- Back-to-back: ack and a new arbitration in the same cycle give a new winner on the next edge with valid staying 1, so throughput is one grant per cycle.
- ack while valid=0 is ignored.
- A mode change takes effect at the next arbitration cycle. ptr is preserved across mode switches.
- multi = (popcount(req) > 1), sampled in the arbitration cycle.
- N that is not a power of 2: code values >= N never occur, and the ptr wrap uses N, not 2^W.

Decomposition:
- Shared package/include pri_enc_pkg holds:
  - State encodings ST_IDLE=1'b0 and ST_HOLD=1'b1.
  - Mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- One natural sub-module, pri_enc_comb. It is a purely combinational parametrised N-to-W encoder with inputs req, base, dir/mode, and outputs idx, onehot, any, multi. It is instantiated once.
- pri_enc_seq holds the FSM, output registers and ptr.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF, en=1, ack=1 -> valid=0, code=0, grant=0, multi=0. Release rst with req=0 -> valid stays 0.
- Fixed: mode=0, en=1, req=8'b0010_1100 -> next edge code=5, grant=8'h20, valid=1, multi=1. Then req=0, ack=0 for 3 cycles -> outputs unchanged. Then ack=1 -> valid=0, grant=0.
- RR rotation: after reset, mode=1, en=1, req=8'hFF, ack=1 constantly -> code=0,1,2,...,7,0 on consecutive cycles, with valid continuously 1.
- RR wrap/skip: after a grant of code 6 (ptr=7), req=8'b0000_0011 with ack -> code=0, then code=1, multi=1 both times. Then req=8'b0000_0001 -> code=0, multi=0.
- Gating: en=0, req=8'h81 -> valid stays 0. ack=1 while valid=0 -> no effect. In HOLD, ack=1 with en=0 -> valid=0 next edge.
- Reset mid-operation: RR mode, ptr=4, valid=1, assert rst with ack=0 -> next edge valid=0, grant=0. Then req=8'hFF, mode=1 -> code=0, confirming ptr was reset.

Source files
------------

// File: rtl/pri_enc_pkg.sv
// Shared constants for the registered priority encoder / arbiter.
package pri_enc_pkg;

  // Arbiter FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Arbitration mode select
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Increment an index modulo n (n need not be a power of two)
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// Combinational N-to-W encoder: fixed (highest index) or rotating-base search.
module pri_enc_comb
  import pri_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any,
  output logic         multi
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  idx_hi;
  logic          hit_hi;
  logic [W-1:0]  idx_lo;

  // Population count for the multiple-request flag
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(req[i]);
    end
  end

  // Lowest set index at or above base, and lowest set index overall (wrap case)
  always_comb begin
    idx_hi = '0;
    hit_hi = 1'b0;
    idx_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = W'(i);
        if (i >= int'(base)) begin
          idx_hi = W'(i);
          hit_hi = 1'b1;
        end
      end
    end
  end

  // Winner selection and one-hot expansion
  always_comb begin
    idx = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end else begin
      idx = hit_hi ? idx_hi : idx_lo;
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

  assign any   = |req;
  assign multi = (cnt > CW'(1));

endmodule

// File: rtl/pri_enc_seq.sv
// Registered N-input priority arbiter with fixed/round-robin modes and valid/ack hold.
module pri_enc_seq
  import pri_enc_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         mode,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] grant,
  output logic         multi
);

  logic [0:0]   state, state_d;
  logic [W-1:0] ptr, ptr_d;
  logic         valid_d;
  logic [W-1:0] code_d;
  logic [N-1:0] grant_d;
  logic         multi_d;

  logic [W-1:0] win_idx;
  logic [N-1:0] win_onehot;
  logic         win_any;
  logic         win_multi;
  logic         take;

  pri_enc_comb #(
    .N (N),
    .W (W)
  ) u_comb (
    .req    (req),
    .base   (ptr),
    .mode   (mode),
    .idx    (win_idx),
    .onehot (win_onehot),
    .any    (win_any),
    .multi  (win_multi)
  );

  // Next state and next output values
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    valid_d = valid;
    code_d  = code;
    grant_d = grant;
    multi_d = multi;
    take    = 1'b0;

    case (state)
      ST_IDLE: take = en && win_any;
      ST_HOLD: take = ack && en && win_any;
    endcase

    if (take) begin
      state_d = ST_HOLD;
      valid_d = 1'b1;
      code_d  = win_idx;
      grant_d = win_onehot;
      multi_d = win_multi;
      if (mode == MODE_RR) begin
        ptr_d = W'(wrap_inc(32'(win_idx), N));
      end
    end else if ((state == ST_HOLD) && ack) begin
      // Consumer took the grant and nothing new to award
      state_d = ST_IDLE;
      valid_d = 1'b0;
      grant_d = '0;
    end
  end

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      valid <= 1'b0;
      code  <= '0;
      grant <= '0;
      multi <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      valid <= valid_d;
      code  <= code_d;
      grant <= grant_d;
      multi <= multi_d;
    end
  end

endmodule

// File: tb/tb_pri_enc_seq.sv
// Scoreboard bench for pri_enc_seq: directed scenarios plus random traffic.
module tb_pri_enc_seq;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef struct packed {
    logic [W-1:0] code;
    logic [N-1:0] grant;
    logic         multi;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         en;
  logic         mode;
  logic         ack;
  logic         valid;
  logic [W-1:0] code;
  logic [N-1:0] grant;
  logic         multi;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_valid = 1'b0;
  int   m_ptr   = 0;

  pri_enc_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (en),
    .mode  (mode),
    .ack   (ack),
    .valid (valid),
    .code  (code),
    .grant (grant),
    .multi (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: highest set bit
  function automatic int fixed_win(input logic [N-1:0] r);
    int w = 0;
    for (int i = 0; i < N; i++) if (r[i]) w = i;
    return w;
  endfunction

  // Reference: rotate so ptr is bit 0, take lowest set bit, rotate back
  function automatic int rr_win(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] d;
    int w = 0;
    d = {r, r} >> p;
    for (int i = N - 1; i >= 0; i--) if (d[i]) w = i;
    return (w + p) % N;
  endfunction

  // Drive one cycle of inputs, advance the model, push any grant it predicts
  task automatic step(input bit r, input logic [N-1:0] rq, input bit e, input bit m, input bit a);
    exp_t x;
    int   w;
    rst = r; req = rq; en = e; mode = m; ack = a;
    if (r) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if ((!m_valid || a) && e && (rq != '0)) begin
      w       = m ? rr_win(rq, m_ptr) : fixed_win(rq);
      x.code  = W'(w);
      x.grant = N'(1) << w;
      x.multi = ($countones(rq) > 1);
      q.push_back(x);
      m_valid = 1'b1;
      if (m) m_ptr = (w + 1) % N;
    end else if (m_valid && a) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
  endtask

  // Monitor: pop on every newly presented grant, otherwise verify it is held
  initial begin
    bit   pv = 1'b0;
    bit   pa = 1'b0;
    exp_t cur = '0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (!pv || pa) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got code %0d with no expected grant at %0t", code, $time);
          end else begin
            cur = q.pop_front();
            chk("code", 32'(code), 32'(cur.code));
            chk("grant", 32'(grant), 32'(cur.grant));
            chk("multi", 32'(multi), 32'(cur.multi));
          end
        end else begin
          chk("hold_code", 32'(code), 32'(cur.code));
          chk("hold_grant", 32'(grant), 32'(cur.grant));
          chk("hold_multi", 32'(multi), 32'(cur.multi));
        end
      end else begin
        chk("idle_grant", 32'(grant), 32'd0);
      end
      pv = (valid === 1'b1);
      pa = (ack === 1'b1);
    end
  end

  initial begin
    // Reset with everything asserted
    step(1, 8'hFF, 1, 0, 1);
    step(1, 8'hFF, 1, 0, 1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_multi", 32'(multi), 32'd0);
    step(0, 8'h00, 1, 0, 1);

    // Fixed priority and hold
    step(0, 8'b0010_1100, 1, 0, 0);
    chk("fix_code", 32'(code), 32'd5);
    chk("fix_grant", 32'(grant), 32'h20);
    chk("fix_multi", 32'(multi), 32'd1);
    repeat (3) begin
      step(0, 8'h00, 1, 0, 0);
      chk("fix_hold_code", 32'(code), 32'd5);
      chk("fix_hold_grant", 32'(grant), 32'h20);
    end
    step(0, 8'h00, 1, 0, 1);
    chk("fix_rel_grant", 32'(grant), 32'd0);
    chk("fix_rel_code", 32'(code), 32'd5);

    // Round-robin rotation from reset
    step(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 1, 1, 1);
      chk("rr_rot_code", 32'(code), 32'(i % 8));
    end

    // Wrap and skip
    step(0, 8'h40, 1, 1, 1);
    chk("rr_code6", 32'(code), 32'd6);
    step(0, 8'b0000_0011, 1, 1, 1);
    chk("rr_wrap_code", 32'(code), 32'd0);
    chk("rr_wrap_multi", 32'(multi), 32'd1);
    step(0, 8'b0000_0011, 1, 1, 1);
    chk("rr_next_code", 32'(code), 32'd1);
    chk("rr_next_multi", 32'(multi), 32'd1);
    step(0, 8'b0000_0001, 1, 1, 1);
    chk("rr_single_code", 32'(code), 32'd0);
    chk("rr_single_multi", 32'(multi), 32'd0);

    // Gating by en, ack while idle
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h81, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h81, 1, 0, 0);
    chk("gate_code", 32'(code), 32'd7);
    step(0, 8'h81, 0, 0, 1);
    chk("gate_rel_grant", 32'(grant), 32'd0);

    // Reset in the middle of a held round-robin grant
    step(1, 8'h00, 0, 0, 0);
    repeat (4) step(0, 8'hFF, 1, 1, 1);
    chk("mid_code3", 32'(code), 32'd3);
    step(1, 8'hFF, 1, 1, 0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    step(0, 8'hFF, 1, 1, 0);
    chk("mid_ptr_code", 32'(code), 32'd0);

    // Random traffic
    repeat (800) begin
      logic [N-1:0] r;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(0, N - 1);
        default: r = N'($urandom);
      endcase
      step(($urandom_range(0, 63) == 0), r, ($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
    end

    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
